// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the hazard unit.
// master = datapath side (drives register ids/status), slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic [4:0]  RdM;
    logic [4:0]  RdW;
    logic        LoadE;
    logic        RegWriteM;
    logic        RegWriteW;
    logic        PCSrcE;
    logic        MulStartE;
    logic        MulDoneE;

    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        FlushD;
    logic        FlushE;
    logic        FlushM;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic        MulBusy;
    logic        MulTimeout;
    logic [15:0] StallCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output LoadE, RegWriteM, RegWriteW, PCSrcE, MulStartE, MulDoneE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  ForwardAE, ForwardBE, MulBusy, MulTimeout, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  LoadE, RegWriteM, RegWriteW, PCSrcE, MulStartE, MulDoneE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output ForwardAE, ForwardBE, MulBusy, MulTimeout, StallCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: forwarding, load-use stalls, branch flushes,
// and a multi-cycle mul/div wait state guarded by a 64-cycle watchdog.
module pipeline_hazard_ctrl (
    input  logic                       clk,
    input  logic                       rst_n,
    pipeline_hazard_ctrl_if.slave      hz
);

    typedef enum logic {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [5:0]  watchdog;
    logic [5:0]  watchdogNext;
    logic        timeoutNext;
    logic        lwStall;
    logic        mulHold;
    logic        stallAny;
    logic [15:0] stallCount;
    logic        mulBusy;
    logic        mulTimeout;

    // Memory stage wins over Writeback; x0 is hard-wired zero so never forwarded.
    function automatic logic [1:0] forwardSel(
        input logic [4:0] rs,
        input logic       regWriteM,
        input logic [4:0] rdM,
        input logic       regWriteW,
        input logic [4:0] rdW
    );
        if (regWriteM && (rdM != 5'd0) && (rdM == rs)) begin
            return 2'b10;
        end else if (regWriteW && (rdW != 5'd0) && (rdW == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    always_comb begin
        lwStall  = 1'b0;
        mulHold  = 1'b0;
        lwStall  = hz.LoadE && (hz.RdE != 5'd0) &&
                   ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) &&
                   (state == RUN);
        mulHold  = ((state == MULWAIT) && !hz.MulDoneE) ||
                   ((state == RUN) && hz.MulStartE && !hz.PCSrcE);
        stallAny = lwStall || mulHold;
    end

    // MulDoneE is checked before the watchdog so a coincident done suppresses the timeout.
    always_comb begin
        nextState    = state;
        watchdogNext = watchdog;
        timeoutNext  = 1'b0;
        case (state)
            RUN: begin
                if (hz.MulStartE && !hz.PCSrcE) begin
                    nextState    = MULWAIT;
                    watchdogNext = 6'd0;
                end
            end
            MULWAIT: begin
                if (hz.MulDoneE) begin
                    nextState    = RUN;
                    watchdogNext = 6'd0;
                end else if (watchdog == 6'd63) begin
                    nextState    = RUN;
                    watchdogNext = 6'd0;
                    timeoutNext  = 1'b1;
                end else begin
                    watchdogNext = watchdog + 6'd1;
                end
            end
            default: begin
                nextState    = RUN;
                watchdogNext = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            watchdog   <= 6'd0;
            mulBusy    <= 1'b0;
            mulTimeout <= 1'b0;
            stallCount <= 16'd0;
        end else begin
            state      <= nextState;
            watchdog   <= watchdogNext;
            mulBusy    <= (nextState == MULWAIT);
            mulTimeout <= timeoutNext;
            if (stallAny && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

    assign hz.StallF     = stallAny;
    assign hz.StallD     = stallAny;
    assign hz.StallE     = mulHold;
    assign hz.FlushM     = mulHold;
    assign hz.FlushD     = hz.PCSrcE && (state == RUN);
    assign hz.FlushE     = (lwStall || hz.PCSrcE) && !mulHold;
    assign hz.ForwardAE  = forwardSel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    assign hz.ForwardBE  = forwardSel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
    assign hz.MulBusy    = mulBusy;
    assign hz.MulTimeout = mulTimeout;
    assign hz.StallCount = stallCount;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Rs1D, Rs2D  input  5 each  source registers of the instruction in Decode.
REQ-005 Rs1E, Rs2E, RdE  input  5 each  source and destination registers in Execute.
REQ-006 RdM, RdW  input  5 each  destination registers in Memory and Writeback.
REQ-007 LoadE  input  1  instruction in Execute is a load.
REQ-008 RegWriteM, RegWriteW  input  1 each  register write enables in Memory and Writeback.
REQ-009 PCSrcE  input  1  taken branch or jump resolved in Execute.
REQ-010 MulStartE  input  1  multi-cycle mul/div op enters Execute this cycle.
REQ-011 MulDoneE  input  1  multi-cycle unit result valid this cycle.
REQ-012 StallF, StallD, StallE  output  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-013 FlushD, FlushE, FlushM  output  1 each  clear IF/ID, ID/EX and EX/MEM to a bubble.
REQ-014 ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 register file, 10 from Memory, 01 from Writeback.
REQ-015 MulBusy  output  1  high while the FSM is in MULWAIT.
REQ-016 MulTimeout  output  1  one-cycle pulse on watchdog expiry.
REQ-017 StallCount  output  16  saturating count of cycles with StallF high.

Function
REQ-018 The FSM SHALL have two states, RUN and MULWAIT.
REQ-019 RUN SHALL go to MULWAIT on a clock edge with MulStartE=1 and PCSrcE=0.
REQ-020 MULWAIT SHALL go to RUN on a clock edge with MulDoneE=1, or on watchdog expiry.
REQ-021 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00.
REQ-022 ForwardBE SHALL follow the REQ-021 rule using Rs2E.
REQ-023 Memory SHALL have priority over Writeback; register x0 SHALL never be forwarded.
REQ-024 Forwarding outputs SHALL be combinational and valid in both FSM states.
REQ-025 lwStall SHALL be LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & state==RUN.
REQ-026 mulHold SHALL be (state==MULWAIT & !MulDoneE) | (state==RUN & MulStartE & !PCSrcE).
REQ-027 StallF and StallD SHALL equal lwStall | mulHold.
REQ-028 StallE and FlushM SHALL equal mulHold.
REQ-029 FlushD SHALL equal PCSrcE & state==RUN.
REQ-030 FlushE SHALL equal (lwStall | PCSrcE) & !mulHold.
REQ-031 PCSrcE SHALL be ignored while in MULWAIT.
REQ-032 On the MulDoneE cycle, all stalls SHALL release combinationally in that same cycle (zero added latency).
REQ-033 A 6-bit watchdog SHALL clear on entry to MULWAIT and increment each MULWAIT cycle without MulDoneE.
REQ-034 When the watchdog value is 63 in MULWAIT without MulDoneE, MulTimeout SHALL pulse for one cycle, the FSM SHALL return to RUN, and the watchdog SHALL clear.
REQ-035 If MulDoneE and watchdog expiry coincide, MulDoneE SHALL win and no timeout pulse SHALL occur.
REQ-036 StallCount SHALL increment on each edge where StallF=1 and SHALL hold at 16'hFFFF, with no wrap.
REQ-037 MulBusy SHALL be registered, equal to (state==MULWAIT).

Reset
REQ-038 With rst_n=0, the block SHALL immediately force state=RUN, watchdog=0, StallCount=0, MulBusy=0 and MulTimeout=0, independent of clk.
REQ-039 Reset asserted mid-MULWAIT SHALL abort the operation; with all inputs at 0, every output SHALL be 0.
REQ-040 The first active edge after rst_n rises SHALL evaluate normally, with no extra bubble inserted.

Verification
REQ-041 The bench SHALL cover load-use: LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for one cycle, StallCount=1; RdE=0 -> no stall.
REQ-042 The bench SHALL cover forwarding priority: RdM=RdW=Rs1E=7, RegWriteM=RegWriteW=1 -> ForwardAE=10; RegWriteM=0 -> 01; all Rd=0 -> 00.
REQ-043 The bench SHALL cover a multi-cycle op: MulStartE pulse, MulDoneE 4 cycles later -> StallF/D/E and FlushM high for 4 cycles, MulBusy high for 4 cycles, released on the done cycle.
REQ-044 The bench SHALL cover the watchdog: MulStartE with no MulDoneE -> MulTimeout pulses once, 64 cycles after entry, then state RUN and StallF=0; the same test with MulDoneE on the expiry cycle -> no pulse.
REQ-045 The bench SHALL cover branches: PCSrcE=1 in RUN -> FlushD=FlushE=1 with no stall; PCSrcE=1 in MULWAIT -> no flush.
REQ-046 The bench SHALL cover saturation and reset: force StallCount to 16'hFFFE, stall 3 cycles -> 16'hFFFF; rst_n low mid-MULWAIT -> all outputs 0 asynchronously.
